wishbone_slave_ram: RTL and testbench

//   Wishbone classic single-transfer responder backed by on-chip word RAM.

---
 rtl/wishbone_slave_ram.sv | 113 +++++++++++
 tb/tb_wishbone_slave_ram.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_slave_ram.sv
// wishbone_slave_ram: Wishbone classic single-transfer slave backed by word RAM, programmable wait states
// Ports:
//   clk, rst_n       clock (rising edge), synchronous active-low reset
//   wb_cyc_i/stb_i   bus cycle / transfer strobe
//   wb_we_i          1=write, 0=read
//   wb_sel_i[3:0]    byte lane enables
//   wb_adr_i[31:0]   byte address
//   wb_dat_i[31:0]   write data
//   wb_dat_o[31:0]   read data, nonzero only alongside wb_ack_o
//   wb_ack_o         normal termination pulse
//   wb_err_o         error termination pulse (out of range or misaligned)
module wishbone_slave_ram #(
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o
);
    localparam int         AW = $clog2(DEPTH);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state, state_d;
    logic [3:0]    cnt, cnt_d;
    logic [31:0]   adr_q, dat_q;
    logic [3:0]    sel_q;
    logic          we_q;
    logic [31:0]   ram [DEPTH];
    logic [31:0]   req_adr, req_dat;
    logic [3:0]    req_sel;
    logic          req_we;
    logic          accept, hit, enter_resp, ram_we;
    logic          ack_d, err_d;
    logic [31:0]   dat_d;
    logic [AW-1:0] idx;

    // With zero wait states the response is formed on the accepting edge, so
    // decode must look at the live inputs in IDLE and the captured copy later.
    always_comb begin
        accept  = (state == IDLE) && wb_cyc_i && wb_stb_i;
        req_adr = (state == IDLE) ? wb_adr_i : adr_q;
        req_dat = (state == IDLE) ? wb_dat_i : dat_q;
        req_sel = (state == IDLE) ? wb_sel_i : sel_q;
        req_we  = (state == IDLE) ? wb_we_i  : we_q;
        // BASE_ADDR is aligned to the RAM size, so range check is a tag compare
        hit     = (req_adr[31:AW+2] == BASE_ADDR[31:AW+2]) && (req_adr[1:0] == 2'b00);
        idx     = req_adr[AW+1:2];
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE: if (accept) begin
                cnt_d   = WS;
                state_d = (WAIT_STATES == 0) ? RESP : WAIT;
            end
            WAIT: if (!wb_cyc_i) begin
                cnt_d   = '0;
                state_d = IDLE;
            end else begin
                cnt_d   = cnt - 4'd1;
                state_d = (cnt == 4'd1) ? RESP : WAIT;
            end
            default: state_d = IDLE;
        endcase
        enter_resp = (state_d == RESP);
        ack_d      = enter_resp && hit;
        err_d      = enter_resp && !hit;
        dat_d      = (enter_resp && hit && !req_we) ? ram[idx] : 32'h0;
        ram_we     = rst_n && enter_resp && hit && req_we;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            adr_q    <= '0;
            dat_q    <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            wb_ack_o <= ack_d;
            wb_err_o <= err_d;
            wb_dat_o <= dat_d;
            if (accept) begin
                adr_q <= wb_adr_i;
                dat_q <= wb_dat_i;
                sel_q <= wb_sel_i;
                we_q  <= wb_we_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we)
            for (int i = 0; i < 4; i++)
                if (req_sel[i]) ram[idx][8*i +: 8] <= req_dat[8*i +: 8];
    end
endmodule

// File: tb/tb_wishbone_slave_ram.sv
// tb_wishbone_slave_ram: randomized bench for wishbone_slave_ram against an array-based memory model
module tb_wishbone_slave_ram;
    localparam int N = 4;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc [N];
    logic        stb [N];
    logic        we [N];
    logic [3:0]  sel [N];
    logic [31:0] adr [N];
    logic [31:0] dat_i [N];
    logic [31:0] dat_o [N];
    logic        ack [N];
    logic        err [N];

    logic [31:0] mem [N][DEPTH];
    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        wishbone_slave_ram #(
            .DEPTH(DEPTH),
            .WAIT_STATES(g == 0 ? 0 : g == 1 ? 3 : g == 2 ? 4 : 1),
            .BASE_ADDR(g == 3 ? 32'h8000_0100 : 32'h0)
        ) dut (
            .clk(clk),
            .rst_n(rst_n),
            .wb_cyc_i(cyc[g]),
            .wb_stb_i(stb[g]),
            .wb_we_i(we[g]),
            .wb_sel_i(sel[g]),
            .wb_adr_i(adr[g]),
            .wb_dat_i(dat_i[g]),
            .wb_dat_o(dat_o[g]),
            .wb_ack_o(ack[g]),
            .wb_err_o(err[g])
        );
    end

    function automatic int ws_of(input int d);
        return d == 0 ? 0 : d == 1 ? 3 : d == 2 ? 4 : 1;
    endfunction

    function automatic logic [31:0] base_of(input int d);
        return d == 3 ? 32'h8000_0100 : 32'h0;
    endfunction

    function automatic bit is_hit(input int d, input logic [31:0] a);
        longint lo = longint'(base_of(d));
        longint av = longint'(a);
        return av >= lo && av < lo + 4 * DEPTH && av % 4 == 0;
    endfunction

    function automatic int word_of(input int d, input logic [31:0] a);
        return int'((a - base_of(d)) / 4);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_quiet(input int d, input string tag);
        check($sformatf("%s ack d%0d", tag, d), 32'(ack[d]), 32'h0);
        check($sformatf("%s err d%0d", tag, d), 32'(err[d]), 32'h0);
        check($sformatf("%s dat d%0d", tag, d), dat_o[d], 32'h0);
    endtask

    task automatic release_bus(input int d);
        cyc[d] = 1'b0;
        stb[d] = 1'b0;
        we[d] = 1'b0;
        sel[d] = 4'($urandom);
        adr[d] = $urandom;
        dat_i[d] = $urandom;
    endtask

    // One complete transfer; checks every cycle of the latency window and the idle cycle after.
    task automatic xfer(input int d, input logic w, input logic [3:0] s, input logic [31:0] a,
                        input logic [31:0] wd, input bit hold, output logic [31:0] rd);
        int ws = ws_of(d);
        bit h = is_hit(d, a);
        logic [31:0] exp_rd = (h && !w) ? mem[d][word_of(d, a)] : 32'h0;
        @(negedge clk);
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; sel[d] = s; adr[d] = a; dat_i[d] = wd;
        rd = 32'h0;
        for (int k = 0; k <= ws; k++) begin
            @(posedge clk); #1;
            check($sformatf("ack d%0d k%0d a=%h", d, k, a), 32'(ack[d]), 32'(k == ws && h));
            check($sformatf("err d%0d k%0d a=%h", d, k, a), 32'(err[d]), 32'(k == ws && !h));
            check($sformatf("dat d%0d k%0d a=%h", d, k, a), dat_o[d], k == ws ? exp_rd : 32'h0);
            if (k == ws) rd = dat_o[d];
        end
        if (h && w)
            for (int b = 0; b < 4; b++)
                if (s[b]) mem[d][word_of(d, a)][8*b +: 8] = wd[8*b +: 8];
        if (hold) begin
            @(posedge clk); #1;
            check_quiet(d, "hold");
        end
        @(negedge clk);
        release_bus(d);
        @(posedge clk); #1;
        check_quiet(d, "after");
    endtask

    // Write that is abandoned by dropping cyc before the edge sampled n cycles after accept.
    task automatic abort_xfer(input int d, input logic [31:0] a, input logic [31:0] wd, input int n);
        int ws = ws_of(d);
        @(negedge clk);
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = 1'b1; sel[d] = 4'hF; adr[d] = a; dat_i[d] = wd;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            check_quiet(d, "abort-wait");
        end
        @(negedge clk);
        release_bus(d);
        for (int k = 0; k <= ws + 1; k++) begin
            @(posedge clk); #1;
            check_quiet(d, "aborted");
        end
    endtask

    function automatic logic [31:0] rand_addr(input int d);
        logic [31:0] b = base_of(d);
        int r = $urandom_range(0, 9);
        if (r < 6) return b + 32'(4 * $urandom_range(0, DEPTH - 1));
        if (r == 6) return b + 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
        if (r == 7) return b + 32'(4 * DEPTH + 4 * $urandom_range(0, 15));
        if (r == 8) return b - 32'(4 * $urandom_range(1, 4));
        return $urandom;
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] old;
        rst_n = 1'b0;
        for (int d = 0; d < N; d++) release_bus(d);
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < N; d++) check_quiet(d, "reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int d = 0; d < N; d++)
            for (int i = 0; i < DEPTH; i++)
                xfer(d, 1'b1, 4'hF, base_of(d) + 32'(4 * i), $urandom, 1'b0, rd);

        xfer(0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 1'b0, rd);
        xfer(0, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0, rd);
        check("w0 readback", rd, 32'hDEAD_BEEF);

        xfer(1, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, rd);

        xfer(0, 1'b1, 4'hF, 32'h20, 32'h1122_3344, 1'b0, rd);
        xfer(0, 1'b1, 4'b0101, 32'h20, 32'hAABB_CCDD, 1'b0, rd);
        xfer(0, 1'b0, 4'h3, 32'h20, 32'h0, 1'b0, rd);
        check("byte lanes", rd, 32'h11BB_33DD);
        xfer(0, 1'b1, 4'h0, 32'h20, 32'hFFFF_FFFF, 1'b0, rd);
        xfer(0, 1'b0, 4'hF, 32'h20, 32'h0, 1'b0, rd);
        check("sel0 write", rd, 32'h11BB_33DD);

        xfer(1, 1'b0, 4'hF, 32'(4 * DEPTH), 32'h0, 1'b0, rd);
        xfer(1, 1'b0, 4'hF, 32'h2, 32'h0, 1'b0, rd);
        xfer(1, 1'b1, 4'hF, 32'h2, 32'hCAFE_F00D, 1'b0, rd);
        xfer(1, 1'b1, 4'hF, 32'(4 * DEPTH), 32'hCAFE_F00D, 1'b0, rd);
        xfer(1, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, rd);
        xfer(1, 1'b0, 4'hF, 32'(4 * DEPTH - 4), 32'h0, 1'b0, rd);

        for (int d = 0; d < N; d++) xfer(d, 1'b0, 4'hF, base_of(d) + 32'h4, 32'h0, 1'b1, rd);

        old = mem[2][2];
        abort_xfer(2, 32'h8, 32'h5, 2);
        xfer(2, 1'b0, 4'hF, 32'h8, 32'h0, 1'b0, rd);
        check("abort keeps", rd, old);
        abort_xfer(2, 32'h8, 32'h5, 4);
        abort_xfer(1, 32'hC, 32'h6, 1);

        @(negedge clk);
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; sel[2] = 4'hF; adr[2] = 32'h8; dat_i[2] = 32'h77;
        repeat (2) begin
            @(posedge clk); #1;
            check_quiet(2, "pre-reset");
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_quiet(2, "in-reset");
        @(negedge clk);
        rst_n = 1'b1;
        release_bus(2);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check_quiet(2, "post-reset");
        end
        xfer(2, 1'b0, 4'hF, 32'h8, 32'h0, 1'b0, rd);
        check("reset drops write", rd, old);

        xfer(3, 1'b0, 4'hF, 32'h8000_00FC, 32'h0, 1'b0, rd);
        xfer(3, 1'b0, 4'hF, 32'h8000_0100, 32'h0, 1'b0, rd);
        xfer(3, 1'b0, 4'hF, 32'h8000_01FC, 32'h0, 1'b0, rd);
        xfer(3, 1'b0, 4'hF, 32'h8000_0200, 32'h0, 1'b0, rd);
        xfer(3, 1'b0, 4'hF, 32'h0000_0100, 32'h0, 1'b0, rd);

        for (int i = 0; i < 150; i++)
            for (int d = 0; d < N; d++) begin
                if (ws_of(d) > 0 && $urandom_range(0, 15) == 0)
                    abort_xfer(d, rand_addr(d), $urandom, $urandom_range(1, ws_of(d)));
                else
                    xfer(d, 1'($urandom), 4'($urandom), rand_addr(d), $urandom,
                         $urandom_range(0, 7) == 0, rd);
            end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
